// File: rtl/arbiter_mux2ne1.sv
// Two-requester round-robin arbiter with a registered 2:1 data mux. Accept at N, out_valid at N+1.
// Optional grant locking is enabled by defining ARB_LOCK_EN. Readies are held low while the output is stalled.
module arbiter_mux2ne1 #(
    parameter int W        = 24,
    parameter int MAX_LOCK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in0_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    input  logic [W-1:0] in1_data,
`ifdef ARB_LOCK_EN
    input  logic         in0_lock,
    input  logic         in1_lock,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_src
);

    typedef enum logic [1:0] {IDLE, FULL, LOCKED} state_t;

    if (MAX_LOCK < 1 || MAX_LOCK > 255) begin : g_bad_max_lock
        $error("MAX_LOCK out of range 1..255");
    end

    state_t       state;
    logic         last;
    logic [W-1:0] data_q;
    logic         src_q;
    logic         free;
    logic         gnt_vld;
    logic         gnt;
    logic         accept;

`ifdef ARB_LOCK_EN
    logic         lock_act;
    logic         lock_own;
    logic [7:0]   lock_cnt;
    logic [8:0]   cnt_nxt;
    logic         sel_lock;

    assign cnt_nxt  = {1'b0, lock_cnt} + 9'd1;
    assign sel_lock = gnt ? in1_lock : in0_lock;
`endif

    assign out_valid = (state != IDLE);
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign free      = ~out_valid | out_ready;

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = 1'b0;
`ifdef ARB_LOCK_EN
        if (lock_act) begin
            // While locked, the owner alone may be granted, even when it goes idle.
            gnt_vld = lock_own ? in1_valid : in0_valid;
            gnt     = lock_own;
        end else
`endif
        if (in0_valid && in1_valid) begin
            gnt_vld = 1'b1;
            gnt     = ~last;
        end else if (in0_valid) begin
            gnt_vld = 1'b1;
            gnt     = 1'b0;
        end else if (in1_valid) begin
            gnt_vld = 1'b1;
            gnt     = 1'b1;
        end
    end

    assign accept    = ~rst & free & gnt_vld;
    assign in0_ready = accept & ~gnt;
    assign in1_ready = accept & gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last   <= 1'b1;
            data_q <= '0;
            src_q  <= 1'b0;
`ifdef ARB_LOCK_EN
            lock_act <= 1'b0;
            lock_own <= 1'b0;
            lock_cnt <= '0;
`endif
        end else if (accept) begin
            data_q <= gnt ? in1_data : in0_data;
            src_q  <= gnt;
            last   <= gnt;
            state  <= FULL;
`ifdef ARB_LOCK_EN
            if (sel_lock && (cnt_nxt < 9'(MAX_LOCK))) begin
                lock_act <= 1'b1;
                lock_own <= gnt;
                lock_cnt <= cnt_nxt[7:0];
                state    <= LOCKED;
            end else begin
                // Lock dropped or beat budget exhausted: this beat still goes out.
                lock_act <= 1'b0;
                lock_cnt <= '0;
            end
`endif
        end else if (free) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_arbiter_mux2ne1.sv
// Directed bench for arbiter_mux2ne1: reset, single requester, alternation, stall, reset mid-transfer, lock.
module tb_arbiter_mux2ne1;
    logic        clk = 1'b0;
    logic        rst;
    logic        in0_valid, in1_valid, out_ready;
    logic [23:0] in0_data, in1_data;
    logic        in0_ready, in1_ready, out_valid, out_src;
    logic [23:0] out_data;
`ifdef ARB_LOCK_EN
    logic        in0_lock, in1_lock;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arbiter_mux2ne1 #(.W(24), .MAX_LOCK(3)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
`ifdef ARB_LOCK_EN
        .in0_lock(in0_lock), .in1_lock(in1_lock),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src)
    );

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
        in0_data = 24'h111111; in1_data = 24'h222222;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready cyc=%0d got=%b%b want=00", i, in0_ready, in1_ready);
            end
            edge_step();
            checks++;
            if (out_valid !== 1'b0 || out_data !== 24'h0 || out_src !== 1'b0) begin
                failures++;
                $display("FAIL reset_out cyc=%0d got v=%b d=%h s=%b want v=0 d=000000 s=0",
                         i, out_valid, out_data, out_src);
            end
        end
    endtask

    task automatic test_single();
        rst = 1'b0; in0_valid = 1'b0; in1_valid = 1'b1; in1_data = 24'hABCDEF; out_ready = 1'b1;
        #2;
        checks++;
        if (in0_ready !== 1'b0 || in1_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready got=%b%b want=01", in0_ready, in1_ready);
        end
        edge_step();
        in1_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 24'hABCDEF || out_src !== 1'b1) begin
            failures++;
            $display("FAIL single_out got v=%b d=%h s=%b want v=1 d=abcdef s=1", out_valid, out_data, out_src);
        end
        edge_step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_alternate();
        in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 24'h000001; in1_data = 24'h000002; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++;
            if (in0_ready !== ((i % 2) == 0) || in1_ready !== ((i % 2) == 1)) begin
                failures++;
                $display("FAIL alt_ready beat=%0d got=%b%b want_src=%0d", i, in0_ready, in1_ready, i % 2);
            end
            edge_step();
            checks++;
            if (out_valid !== 1'b1 || out_src !== 1'((i % 2)) || out_data !== 24'(i % 2 + 1)) begin
                failures++;
                $display("FAIL alt_out beat=%0d got v=%b s=%b d=%h want v=1 s=%0d d=%h",
                         i, out_valid, out_src, out_data, i % 2, 24'(i % 2 + 1));
            end
        end
    endtask

    task automatic test_stall();
        in1_valid = 1'b0; in0_data = 24'h000055;
        edge_step();
        in1_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_ready cyc=%0d got=%b%b want=00", i, in0_ready, in1_ready);
            end
            edge_step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 24'h000055 || out_src !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got v=%b d=%h s=%b want v=1 d=000055 s=0",
                         i, out_valid, out_data, out_src);
            end
        end
        out_ready = 1'b1;
        #2;
        checks++;
        if (in0_ready !== 1'b0 || in1_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_resume_ready got=%b%b want=01", in0_ready, in1_ready);
        end
        edge_step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 24'h000002 || out_src !== 1'b1) begin
            failures++;
            $display("FAIL stall_resume_out got v=%b d=%h s=%b want v=1 d=000002 s=1", out_valid, out_data, out_src);
        end
    endtask

    task automatic test_idle_ready();
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        edge_step();
        edge_step();
        checks++;
        if (out_valid !== 1'b0 || in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready got v=%b r=%b%b want v=0 r=00", out_valid, in0_ready, in1_ready);
        end
    endtask

    task automatic test_reset_mid();
        in0_valid = 1'b1; in0_data = 24'h0000AA; out_ready = 1'b0;
        edge_step();
        in1_valid = 1'b1; rst = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b1 || in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_pre got v=%b r=%b%b want v=1 r=00", out_valid, in0_ready, in1_ready);
        end
        edge_step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 24'h0) begin
            failures++;
            $display("FAIL rstmid_out got v=%b d=%h want v=0 d=000000", out_valid, out_data);
        end
        rst = 1'b0; out_ready = 1'b1;
        #2;
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_first_grant got=%b%b want=10", in0_ready, in1_ready);
        end
        edge_step();
        in0_valid = 1'b0; in1_valid = 1'b0;
        edge_step();
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        logic exp_src [4];
        exp_src = '{1'b0, 1'b0, 1'b0, 1'b1};
        rst = 1'b1;
        edge_step();
        rst = 1'b0; in0_valid = 1'b1; in1_valid = 1'b1; in0_lock = 1'b1; in1_lock = 1'b0;
        in0_data = 24'h000001; in1_data = 24'h000002; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            edge_step();
            checks++;
            if (out_valid !== 1'b1 || out_src !== exp_src[i]) begin
                failures++;
                $display("FAIL lock_seq beat=%0d got v=%b s=%b want v=1 s=%b", i, out_valid, out_src, exp_src[i]);
            end
        end
        in0_valid = 1'b0; in1_valid = 1'b0; in0_lock = 1'b0;
        edge_step();
    endtask
`endif

    initial begin
        rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
        in0_data = '0; in1_data = '0;
`ifdef ARB_LOCK_EN
        in0_lock = 1'b0; in1_lock = 1'b0;
`endif
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_idle_ready();
        test_reset_mid();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
